// File: rtl/pipelined_remult_pkg.sv
// pipelined_remult shared types: per-stage bundle and widths.
// REMULT_CHECK_EN adds the expected field to stage_t.
package pipelined_remult_pkg;

  localparam int DIVIDEND_W = 16;
  localparam int DIVISOR_W  = 8;
  localparam int ACC_W      = DIVIDEND_W + DIVISOR_W;

  typedef struct packed {
    logic                  valid;
    logic [DIVIDEND_W-1:0] quotient;
    logic [DIVISOR_W-1:0]  divisor;
    logic [ACC_W-1:0]      acc;
    logic                  dbz;
    logic                  range_err;
`ifdef REMULT_CHECK_EN
    logic [DIVIDEND_W-1:0] expected;
`endif
  } stage_t;

endpackage

// File: rtl/pipelined_remult_if.sv
// pipelined_remult bus: triple in (in_valid, quotient, divisor,
// remainder, expected), result out (out_valid, dividend, flags).
interface pipelined_remult_if #(
  parameter int DIVIDEND = 16,
  parameter int DIVISOR  = 8
);
  logic                        in_valid;
  logic [DIVIDEND-1:0]         quotient;
  logic [DIVISOR-1:0]          divisor;
  logic [DIVISOR-1:0]          remainder;
  logic [DIVIDEND-1:0]         expected;
  logic                        out_valid;
  logic [DIVIDEND+DIVISOR-1:0] dividend;
  logic                        dbz;
  logic                        range_err;
  logic                        ovf;
  logic                        mismatch;
  logic [31:0]                 err_count;

  modport master (
    output in_valid, quotient, divisor,
    output remainder, expected,
    input  out_valid, dividend, dbz,
    input  range_err, ovf, mismatch,
    input  err_count
  );

  modport slave (
    input  in_valid, quotient, divisor,
    input  remainder, expected,
    output out_valid, dividend, dbz,
    output range_err, ovf, mismatch,
    output err_count
  );
endinterface

// File: rtl/pipelined_remult_stage.sv
// One shift-add stage: acc += divisor[BIT] ? quotient << BIT : 0.
// Ports: clock, reset_n, up (previous stage), dn (registered result).
module pipelined_remult_stage
  import pipelined_remult_pkg::*;
#(
  parameter int BIT = 0
) (
  input  logic   clock,
  input  logic   reset_n,
  input  stage_t up,
  output stage_t dn
);

  stage_t nxt;

  always_comb begin
    nxt = up;
    if (up.divisor[BIT])
      nxt.acc = up.acc + (ACC_W'(up.quotient) << BIT);
  end

  // bubbles only move the valid bit; data holds
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      dn <= '0;
    else if (up.valid)
      dn <= nxt;
    else
      dn.valid <= 1'b0;
  end

endmodule

// File: rtl/pipelined_remult.sv
// Rebuilds dividend = quotient*divisor + remainder, 1/clk, DIVISOR lat.
// Ports: clock, reset_n, io (slave). Macro REMULT_CHECK_EN: compare.
module pipelined_remult
  import pipelined_remult_pkg::*;
#(
  parameter int DIVIDEND = DIVIDEND_W,
  parameter int DIVISOR  = DIVISOR_W
) (
  input logic               clock,
  input logic               reset_n,
  pipelined_remult_if.slave io
);

  stage_t s [DIVISOR+1];
  stage_t head;
  stage_t fin;

  always_comb begin
    head           = '0;
    head.valid     = io.in_valid;
    head.quotient  = io.quotient;
    head.divisor   = io.divisor;
    head.acc       = ACC_W'(io.remainder);
    head.dbz       = (io.divisor == '0);
    head.range_err = (io.divisor != '0) &&
                     (io.remainder >= io.divisor);
`ifdef REMULT_CHECK_EN
    head.expected  = io.expected;
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      s[0] <= '0;
    else if (io.in_valid)
      s[0] <= head;
    else
      s[0].valid <= 1'b0;
  end

  for (genvar k = 0; k < DIVISOR; k++) begin : g_stage
    pipelined_remult_stage #(.BIT(k)) u_stage (
      .clock   (clock),
      .reset_n (reset_n),
      .up      (s[k]),
      .dn      (s[k+1])
    );
  end

  assign fin          = s[DIVISOR];
  assign io.out_valid = fin.valid;
  assign io.dividend  = fin.acc;
  assign io.dbz       = fin.dbz;
  assign io.range_err = fin.range_err;
  assign io.ovf       = |fin.acc[ACC_W-1:DIVIDEND];

`ifdef REMULT_CHECK_EN
  logic        mis;
  logic        room;
  logic [31:0] err_q;

  assign mis  = fin.valid && !fin.dbz &&
                (fin.acc != ACC_W'(fin.expected));
  assign room = (err_q != '1);

  // err_count shows the bump in the offending result's own cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      err_q <= '0;
    else if (mis && room)
      err_q <= err_q + 32'd1;
  end

  assign io.mismatch  = mis;
  assign io.err_count = (mis && room) ? err_q + 32'd1 : err_q;

  logic unused_tail;
  assign unused_tail = ^{fin.quotient, fin.divisor};
`else
  assign io.mismatch  = 1'b0;
  assign io.err_count = '0;

  logic unused_tail;
  assign unused_tail = ^{fin.quotient, fin.divisor, io.expected};
`endif

endmodule

// File: tb/tb_pipelined_remult.sv
// pipelined_remult bench: directed steps with a result scoreboard.
// Builds with or without REMULT_CHECK_EN.
module tb_pipelined_remult;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   exp_err = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  pipelined_remult_if #(.DIVIDEND(16), .DIVISOR(8)) bus ();

  pipelined_remult #(.DIVIDEND(16), .DIVISOR(8)) u_dut (
    .clock   (clock),
    .reset_n (reset_n),
    .io      (bus.slave)
  );

  typedef struct {
    logic [23:0] dv;
    logic        dbz;
    logic        rng;
    logic        ovf;
    logic        mis;
    int          at;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] req);
    n_chk++;
    assert (obs === req) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, req);
    end
  endtask

  task automatic send(input logic [15:0] q, input logic [7:0] d,
                      input logic [7:0] r, input logic [15:0] e);
    exp_t x;
    @(negedge clock);
    bus.in_valid  = 1'b1;
    bus.quotient  = q;
    bus.divisor   = d;
    bus.remainder = r;
    bus.expected  = e;
    x.dv  = {8'd0, q} * {16'd0, d} + {16'd0, r};
    x.dbz = (d == 8'd0);
    x.rng = (d != 8'd0) && (r >= d);
    x.ovf = (x.dv[23:16] != 8'd0);
`ifdef REMULT_CHECK_EN
    x.mis = !x.dbz && (x.dv != {8'd0, e});
`else
    x.mis = 1'b0;
`endif
    x.at  = cyc + 1;
    sb.push_back(x);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    idle(1);
    for (int i = 0; i < 40 && sb.size() != 0; i++)
      @(negedge clock);
    chk("drain", sb.size(), 0);
  endtask

  // scoreboard side
  always @(negedge clock) begin
    if (reset_n && bus.out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", 1, 0);
      end else begin
        exp_t x;
        x = sb.pop_front();
        if (x.mis && exp_err != -1) exp_err++;
        chk("latency", cyc, x.at + 8);
        chk("dividend", bus.dividend, x.dv);
        chk("dbz", bus.dbz, x.dbz);
        chk("range_err", bus.range_err, x.rng);
        chk("ovf", bus.ovf, x.ovf);
        chk("mismatch", bus.mismatch, x.mis);
        chk("err_count", bus.err_count, exp_err);
      end
    end
  end

  initial begin
    int k;
    bus.in_valid  = 1'b0;
    bus.quotient  = '0;
    bus.divisor   = '0;
    bus.remainder = '0;
    bus.expected  = '0;

    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_dividend", bus.dividend, 0);
    chk("rst_dbz", bus.dbz, 0);
    chk("rst_range_err", bus.range_err, 0);
    chk("rst_ovf", bus.ovf, 0);
    chk("rst_mismatch", bus.mismatch, 0);
    chk("rst_err_count", bus.err_count, 0);
    idle(3);
    reset_n = 1'b1;
    idle(2);

    // single pulse
    send(16'd1000, 8'd7, 8'd3, 16'd7003);
    drain();

    // back-to-back stream
    for (int q = 0; q < 10; q++)
      send(16'(q), 8'd3, 8'd1, 16'(3 * q + 1));
    drain();

    // boundaries
    send(16'd5, 8'd0, 8'd9, 16'd9);
    send(16'd65535, 8'd255, 8'd254, 16'hffff);
    send(16'd4, 8'd10, 8'd10, 16'd50);
    send(16'd65535, 8'd255, 8'd255, 16'd0);
    drain();

    // random with bubbles and some wrong expecteds
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(3) == 0) begin
        idle(1);
      end else begin
        logic [15:0] q;
        logic [7:0]  d;
        logic [7:0]  r;
        logic [15:0] e;
        q = 16'($urandom);
        d = ($urandom_range(5) == 0) ? 8'd0 : 8'($urandom);
        r = 8'($urandom);
        e = 16'(q * d + r);
        if ($urandom_range(4) == 0) e = e ^ 16'h0100;
        send(q, d, r, e);
      end
    end
    drain();

    // reset with results in flight
    send(16'd11, 8'd2, 8'd0, 16'd22);
    send(16'd12, 8'd2, 8'd0, 16'd24);
    send(16'd13, 8'd2, 8'd0, 16'd26);
    idle(1);
    for (k = 0; k < 20 && !bus.out_valid; k++)
      @(negedge clock);
    chk("reach_output", bus.out_valid, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_clear", bus.out_valid, 0);
    chk("async_err_count", bus.err_count, 0);
    idle(2);
    sb.delete();
    exp_err = 0;
    reset_n = 1'b1;
    idle(12);
    send(16'd300, 8'd9, 8'd4, 16'd2704);
    drain();

    // compare path
    chk("err_before", bus.err_count, 0);
    send(16'd7, 8'd3, 8'd2, 16'd24);
    send(16'd5, 8'd0, 8'd9, 16'd1);
    drain();
    chk("err_after", bus.err_count, exp_err);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_remult.md
# pipelined_remult

Pipelined inverse of the pipelined divider: reconstructs the dividend from a (quotient, divisor, remainder) triple as quotient*divisor + remainder, one result per clock. It sits on the divider's output side as the checker and readback path. It also serves as the self-check engine in exhaustive divider regressions, replacing behavioural multiply in the bench. Each result carries status flags for divide-by-zero, remainder out of range and dividend overflow.

## Interface
- DIVIDEND, 16, dividend/quotient width in bits
- DIVISOR, 8, divisor/remainder width in bits; also the pipeline depth
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- in_valid  input  1  triple presented this cycle
- quotient  input  DIVIDEND  quotient operand
- divisor  input  DIVISOR  divisor operand
- remainder  input  DIVISOR  remainder operand
- expected  input  DIVIDEND  original dividend for compare (used only with the check feature)
- out_valid  output  1  result valid
- dividend  output  DIVIDEND+DIVISOR  reconstructed value, full width
- dbz  output  1  divisor was zero
- range_err  output  1  divisor nonzero and remainder >= divisor
- ovf  output  1  dividend bits [DIVIDEND+DIVISOR-1:DIVIDEND] nonzero
- mismatch  output  1  dividend != zero-extended expected (check feature only)
- err_count  output  32  saturating count of mismatch results (check feature only)

## Operation
- Reset: all stage valid bits cleared. out_valid, dividend, dbz, range_err, ovf, mismatch and err_count are all 0.
- Stage 0, on in_valid:
  - acc = zero-extended remainder.
  - Flags dbz and range_err are computed from the raw inputs.
  - quotient, divisor and expected are registered with the accumulator.
- Stage k, for k = 0..DIVISOR-1: acc += (divisor[k] ? quotient << k : 0). Arithmetic is DIVIDEND+DIVISOR bits wide, unsigned.
- Wrap-around: the sum cannot wrap when remainder < divisor. When range_err=1 the sum is truncated modulo 2^(DIVIDEND+DIVISOR), and this truncation is the required behaviour.
- ovf is evaluated on the final accumulator.
- dbz=1 forces range_err=0. The result is still produced and equals the remainder.
- Backpressure: none. The block accepts a new triple every cycle.
- Bubbles: a cycle with in_valid=0 propagates as a bubble. Data registers in a bubble stage hold their old values, and outputs show stale data with out_valid=0.
- Status flags are meaningful only while out_valid=1.

## Timing
- Latency is exactly DIVISOR cycles: a triple sampled at edge N appears with out_valid=1 after edge N+DIVISOR.
- Throughput: 1 result per cycle; ordering is preserved.
- Reset mid-operation:
  - Assertion of reset_n immediately (asynchronously) clears all valids.
  - In-flight triples are discarded and never emerge.
  - The first valid output after release belongs to a triple sampled after release.
- With the check feature, mismatch and the err_count increment are coincident with the out_valid cycle of the offending result. err_count saturates at 2^32-1.

## Configuration
- REMULT_CHECK_EN defined:
  - The expected port is carried through the pipeline.
  - mismatch and err_count are live.
  - A result with dbz=1 never counts as a mismatch.
- REMULT_CHECK_EN undefined:
  - expected is ignored, and no expected registers are synthesised.
  - mismatch and err_count are tied to 0.

## Structure
- Package pipelined_remult_pkg holds:
  - stage_t, a packed struct {valid, quotient, divisor, acc, dbz, range_err, expected}, with the expected field present only under REMULT_CHECK_EN.
  - A localparam for the accumulator width.
- Sub-module pipelined_remult_stage: one shift-add stage with a bit-index parameter. Instantiate it DIVISOR times in a generate loop.

## Test plan
All scenarios use DIVIDEND=16, DIVISOR=8.
- q=1000, d=7, r=3, single pulse: exactly 8 cycles later dividend=7003, with dbz=range_err=ovf=0.
- Stream q=0..9 with d=3, r=1 on consecutive cycles: outputs are 1, 4, 7, ..., 28 on 10 consecutive out_valid cycles.
- q=5, d=0, r=9: dividend=9, dbz=1, range_err=0.
- q=65535, d=255, r=254: dividend=16711679, ovf=1, range_err=0.
- q=4, d=10, r=10: dividend=50, range_err=1.
- Reset and check feature:
  - Pulse reset_n low with 3 triples in flight: no out_valid for those triples after release.
  - With REMULT_CHECK_EN, q=7, d=3, r=2 with expected=24: mismatch=1 and err_count goes 0 -> 1.
